// File: rtl/cu_pkg.sv
// Shared definitions for the multi-cycle control unit: opcode values,
// sequencer states and the value presented on op while in reset.
package cu_pkg;

    localparam logic [3:0] OP_CLA   = 4'd0;
    localparam logic [3:0] OP_COM   = 4'd1;
    localparam logic [3:0] OP_SHR   = 4'd2;
    localparam logic [3:0] OP_CSL   = 4'd3;
    localparam logic [3:0] OP_STP   = 4'd4;
    localparam logic [3:0] OP_ADD   = 4'd5;
    localparam logic [3:0] OP_STA   = 4'd6;
    localparam logic [3:0] OP_LDA   = 4'd7;
    localparam logic [3:0] OP_JMP   = 4'd8;
    localparam logic [3:0] OP_BAN   = 4'd9;

    localparam logic [3:0] OP_RESET = 4'b0100;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEMRD,
        S_MEMWR,
        S_HALT
    } state_e;

endpackage

// File: rtl/cu_wait_timer.sv
// 8-bit memory wait counter; expire fires on the last permitted wait cycle
// so the sequencer can trap instead of waiting one cycle more.
module cu_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 8'd0;
        end else if (en) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // This wait cycle would bring the count to WAIT_MAX.
    assign expire = en && (cnt_q == 8'(WAIT_MAX - 1));

endmodule

// File: rtl/multicycle_cu.sv
// Multi-cycle sequencer for the accumulator CPU: fetch/decode/execute with
// memory handshakes, branch resolution, halt/resume and a bus-timeout trap.
module multicycle_cu
    import cu_pkg::*;
#(
    parameter int OP_W     = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] ins,
    input  logic            mem_ready,
    input  logic            acc_neg,
    input  logic            run,
    output logic [OP_W-1:0] op,
    output logic            ir_wr,
    output logic            mem_rd,
    output logic            data_wr,
    output logic            acc_wr,
    output logic            pc_wr,
    output logic            pc_inc,
    output logic            stp,
    output logic            illegal,
    output logic            bus_err
);

    state_e          state_q;
    state_e          state_d;
    logic [OP_W-1:0] op_q;
    logic [OP_W-1:0] op_d;
    logic            bus_err_q;
    logic            bus_err_d;

    logic ir_wr_c, mem_rd_c, data_wr_c, acc_wr_c, pc_wr_c, pc_inc_c, stp_c, illegal_c;
    logic wait_en;
    logic wait_clr;
    logic wait_expire;

    assign wait_en  = ((state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR))
                      && !mem_ready;
    // Any state change re-arms the counter for the next memory phase.
    assign wait_clr = (state_d != state_q);

    cu_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (wait_clr),
        .en     (wait_en),
        .expire (wait_expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            op_q      <= OP_W'(OP_RESET);
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            bus_err_q <= bus_err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        bus_err_d = bus_err_q;
        ir_wr_c   = 1'b0;
        mem_rd_c  = 1'b0;
        data_wr_c = 1'b0;
        acc_wr_c  = 1'b0;
        pc_wr_c   = 1'b0;
        pc_inc_c  = 1'b0;
        stp_c     = 1'b0;
        illegal_c = 1'b0;

        case (state_q)
            S_FETCH: begin
                mem_rd_c = 1'b1;
                if (mem_ready) begin
                    ir_wr_c = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_expire) begin
                    mem_rd_c  = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_DECODE: begin
                op_d = ins;
                case (ins)
                    OP_W'(OP_STP):                 state_d = S_HALT;
                    OP_W'(OP_ADD), OP_W'(OP_LDA):  state_d = S_MEMRD;
                    OP_W'(OP_STA):                 state_d = S_MEMWR;
                    OP_W'(OP_CLA), OP_W'(OP_COM), OP_W'(OP_SHR),
                    OP_W'(OP_CSL), OP_W'(OP_JMP), OP_W'(OP_BAN):
                                                   state_d = S_EXEC;
                    default: begin
                        // Skip the bad word and carry on with the next one.
                        illegal_c = 1'b1;
                        pc_inc_c  = 1'b1;
                        state_d   = S_FETCH;
                    end
                endcase
            end
            S_EXEC: begin
                state_d = S_FETCH;
                case (op_q)
                    OP_W'(OP_JMP): pc_wr_c = 1'b1;
                    OP_W'(OP_BAN): begin
                        if (acc_neg) begin
                            pc_wr_c = 1'b1;
                        end else begin
                            pc_inc_c = 1'b1;
                        end
                    end
                    default: begin
                        acc_wr_c = 1'b1;
                        pc_inc_c = 1'b1;
                    end
                endcase
            end
            S_MEMRD: begin
                mem_rd_c = 1'b1;
                if (mem_ready) begin
                    acc_wr_c = 1'b1;
                    pc_inc_c = 1'b1;
                    state_d  = S_FETCH;
                end else if (wait_expire) begin
                    mem_rd_c  = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_MEMWR: begin
                data_wr_c = 1'b1;
                if (mem_ready) begin
                    pc_inc_c = 1'b1;
                    state_d  = S_FETCH;
                end else if (wait_expire) begin
                    data_wr_c = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_HALT: begin
                stp_c = 1'b1;
                if (run) begin
                    pc_inc_c = 1'b1;
                    state_d  = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Reset masks every strobe combinationally so an aborted instruction
    // cannot emit a write while rst_n is low.
    assign op      = rst_n ? op_q : OP_W'(OP_RESET);
    assign ir_wr   = rst_n & ir_wr_c;
    assign mem_rd  = rst_n & mem_rd_c;
    assign data_wr = rst_n & data_wr_c;
    assign acc_wr  = rst_n & acc_wr_c;
    assign pc_wr   = rst_n & pc_wr_c;
    assign pc_inc  = rst_n & pc_inc_c;
    assign stp     = rst_n & stp_c;
    assign illegal = rst_n & illegal_c;
    assign bus_err = rst_n & bus_err_q;

endmodule

// File: tb/tb_multicycle_cu.sv
// Self-checking bench for multicycle_cu: per-instruction strobe sequences
// derived from the instruction rules, with randomized waits and noise inputs.
module tb_multicycle_cu;

    localparam logic [8:0] IR  = 9'h100;
    localparam logic [8:0] RD  = 9'h080;
    localparam logic [8:0] DW  = 9'h040;
    localparam logic [8:0] AW  = 9'h020;
    localparam logic [8:0] PW  = 9'h010;
    localparam logic [8:0] PI  = 9'h008;
    localparam logic [8:0] ST  = 9'h004;
    localparam logic [8:0] IL  = 9'h002;
    localparam logic [8:0] BE  = 9'h001;
    localparam logic [8:0] ALL = 9'h1FF;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] ins;
    logic       mem_ready;
    logic       acc_neg;
    logic       run;
    logic [3:0] op;
    logic       ir_wr, mem_rd, data_wr, acc_wr, pc_wr, pc_inc, stp, illegal, bus_err;

    int         checks = 0;
    int         fails  = 0;
    logic [3:0] exp_op;
    logic       exp_be;

    always #5 clk = ~clk;

    multicycle_cu #(
        .OP_W     (4),
        .WAIT_MAX (15)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ins       (ins),
        .mem_ready (mem_ready),
        .acc_neg   (acc_neg),
        .run       (run),
        .op        (op),
        .ir_wr     (ir_wr),
        .mem_rd    (mem_rd),
        .data_wr   (data_wr),
        .acc_wr    (acc_wr),
        .pc_wr     (pc_wr),
        .pc_inc    (pc_inc),
        .stp       (stp),
        .illegal   (illegal),
        .bus_err   (bus_err)
    );

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] r4();
        return 4'($urandom_range(0, 15));
    endfunction

    // One clock cycle: drive inputs after the falling edge, then check outputs.
    task automatic do_cycle(input logic rn, input logic mr, input logic an, input logic rr,
                            input logic [3:0] iv, input logic [8:0] exp,
                            input logic [8:0] mask, input string tag);
        logic [8:0] obs;
        logic [8:0] e;
        logic [3:0] eop;
        @(negedge clk);
        rst_n     = rn;
        mem_ready = mr;
        acc_neg   = an;
        run       = rr;
        ins       = iv;
        #1;
        obs = {ir_wr, mem_rd, data_wr, acc_wr, pc_wr, pc_inc, stp, illegal, bus_err};
        e   = rn ? (exp | (exp_be ? BE : 9'h000)) : 9'h000;
        eop = rn ? exp_op : 4'b0100;
        checks++;
        assert ((obs & mask) === (e & mask)) else begin
            fails++;
            $error("FAIL %s strobes(ir,rd,dw,aw,pw,pi,st,il,be)=%b expected=%b",
                   tag, obs & mask, e & mask);
        end
        checks++;
        assert (op === eop) else begin
            fails++;
            $error("FAIL %s_op op=%h expected=%h", tag, op, eop);
        end
    endtask

    // Cycle where run/acc_neg/ins are don't-care noise.
    task automatic nc(input logic mr, input logic [8:0] exp, input string tag);
        do_cycle(1'b1, mr, rb(), rb(), r4(), exp, ALL, tag);
    endtask

    task automatic exec_instr(input logic [3:0] opc, input int fw, input int mw,
                              input logic neg, input int hc);
        for (int i = 0; i < fw; i++) nc(1'b0, RD, "fetch_wait");
        nc(1'b1, RD | IR, "fetch");
        if (opc > 4'd9) begin
            do_cycle(1'b1, rb(), rb(), rb(), opc, IL | PI, ALL, "decode_illegal");
            exp_op = opc;
        end else begin
            do_cycle(1'b1, rb(), rb(), rb(), opc, 9'h000, ALL, "decode");
            exp_op = opc;
            case (opc)
                4'd4: begin
                    for (int i = 0; i < hc; i++)
                        do_cycle(1'b1, rb(), rb(), 1'b0, r4(), ST, ALL, "halt");
                    do_cycle(1'b1, rb(), rb(), 1'b1, r4(), ST | PI, ALL, "resume");
                end
                4'd5, 4'd7: begin
                    for (int i = 0; i < mw; i++) nc(1'b0, RD, "rd_wait");
                    nc(1'b1, RD | AW | PI, "rd_done");
                end
                4'd6: begin
                    for (int i = 0; i < mw; i++) nc(1'b0, DW, "wr_wait");
                    nc(1'b1, DW | PI, "wr_done");
                end
                4'd8: nc(rb(), PW, "jmp");
                4'd9: do_cycle(1'b1, rb(), neg, rb(), r4(), neg ? PW : PI, ALL, "ban");
                default: nc(rb(), AW | PI, "alu");
            endcase
        end
    endtask

    initial begin
        rst_n = 1'b0; ins = 4'd0; mem_ready = 1'b0; acc_neg = 1'b0; run = 1'b0;
        exp_op = 4'b0100;
        exp_be = 1'b0;

        // Reset held two cycles with noisy inputs.
        do_cycle(1'b0, 1'b1, rb(), 1'b1, r4(), 9'h000, ALL, "reset0");
        do_cycle(1'b0, 1'b1, rb(), 1'b1, r4(), 9'h000, ALL, "reset1");

        // Zero-wait program CLA; COM; ADD; STA; STP.
        exec_instr(4'd0, 0, 0, 1'b0, 0);
        exec_instr(4'd1, 0, 0, 1'b0, 0);
        exec_instr(4'd5, 0, 0, 1'b0, 0);
        exec_instr(4'd6, 0, 0, 1'b0, 0);
        exec_instr(4'd4, 0, 0, 1'b0, 3);

        // LDA with four wait cycles; BAN taken then not taken; illegal opcode.
        exec_instr(4'd7, 0, 4, 1'b0, 0);
        exec_instr(4'd9, 0, 0, 1'b1, 0);
        exec_instr(4'd9, 0, 0, 1'b0, 0);
        exec_instr(4'd14, 0, 0, 1'b0, 0);
        exec_instr(4'd8, 2, 0, 1'b0, 0);

        // Longest wait that still completes, in both memory phases.
        exec_instr(4'd5, 14, 14, 1'b0, 0);
        exec_instr(4'd6, 1, 14, 1'b0, 0);

        // Reset in the middle of STA: no write strobe, next cycle is FETCH.
        nc(1'b1, RD | IR, "fetch_sta");
        do_cycle(1'b1, rb(), rb(), rb(), 4'd6, 9'h000, ALL, "decode_sta");
        exp_op = 4'd6;
        do_cycle(1'b0, 1'b1, rb(), rb(), r4(), 9'h000, ALL, "reset_mid");
        exp_op = 4'b0100;
        exec_instr(4'd2, 0, 0, 1'b0, 0);

        // Fetch timeout: 15 cycles with mem_ready low, then trap to HALT.
        for (int i = 0; i < 14; i++) nc(1'b0, RD, "to_wait");
        do_cycle(1'b1, 1'b0, rb(), rb(), r4(), 9'h000, ALL & ~RD, "to_expire");
        exp_be = 1'b1;
        for (int i = 0; i < 3; i++)
            do_cycle(1'b1, rb(), rb(), 1'b0, r4(), ST, ALL, "to_halt");
        do_cycle(1'b1, rb(), rb(), 1'b1, r4(), ST | PI, ALL, "to_resume");
        exec_instr(4'd3, 0, 0, 1'b0, 0);
        exec_instr(4'd7, 1, 2, 1'b0, 0);

        // Timeout in a write phase while bus_err is already sticky.
        nc(1'b1, RD | IR, "fetch_sta2");
        do_cycle(1'b1, rb(), rb(), rb(), 4'd6, 9'h000, ALL, "decode_sta2");
        exp_op = 4'd6;
        for (int i = 0; i < 14; i++) nc(1'b0, DW, "wr_to_wait");
        do_cycle(1'b1, 1'b0, rb(), rb(), r4(), 9'h000, ALL & ~DW, "wr_to_expire");
        do_cycle(1'b1, rb(), rb(), 1'b1, r4(), ST | PI, ALL, "wr_to_resume");

        // Only reset clears bus_err.
        do_cycle(1'b0, rb(), rb(), rb(), r4(), 9'h000, ALL, "reset_clr");
        exp_op = 4'b0100;
        exp_be = 1'b0;
        exec_instr(4'd0, 0, 0, 1'b0, 0);

        // Randomized instruction stream.
        for (int n = 0; n < 60; n++) begin
            logic [3:0] opc;
            int         fw;
            int         mw;
            opc = r4();
            fw  = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 3));
            mw  = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 3));
            exec_instr(opc, fw, mw, rb(), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
